// File: rtl/y86_fetch_queue_if.sv
// Fetch-queue bus bundle: ROM beat request/ack, decode valid/ready and pipeline redirect.
// master = fetch queue side, slave = ROM / decode / redirect source side.
interface y86_fetch_queue_if #(
  parameter int WORD_W      = 32,
  parameter int INST_BYTES  = 6,
  parameter int FETCH_BYTES = 4
);
  logic                     redirect_i;
  logic [WORD_W-1:0]        redirect_pc_i;
  logic                     rom_req_o;
  logic [WORD_W-1:0]        rom_addr_o;
  logic                     rom_ack_i;
  logic [8*FETCH_BYTES-1:0] rom_data_i;
  logic                     inst_valid_o;
  logic                     inst_ready_i;
  logic [8*INST_BYTES-1:0]  inst_o;
  logic [WORD_W-1:0]        inst_pc_o;
  logic [3:0]               inst_len_o;
  logic                     inst_err_o;

  modport master (
    input  redirect_i, redirect_pc_i, rom_ack_i, rom_data_i, inst_ready_i,
    output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_len_o, inst_err_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, rom_ack_i, rom_data_i, inst_ready_i,
    input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_len_o, inst_err_o
  );
endinterface

// File: rtl/y86_fetch_queue.sv
// Y86 fetch front-end: ROM beats into a circular byte queue, whole instructions out to decode.
// Optional Y86_FETCH_PERF_EN adds saturating beat / starve counters.
//
// state | meaning
// IDLE  | no beat outstanding; issue when a full beat fits in the queue
// REQ   | beat outstanding; data lands at tail on ack
// DROP  | beat outstanding but stale after a redirect; data discarded on ack
module y86_fetch_queue #(
  parameter int                WORD_W      = 32,
  parameter int                INST_BYTES  = 6,
  parameter int                FETCH_BYTES = 4,
  parameter int                BUF_BYTES   = 16,
  parameter logic [WORD_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  y86_fetch_queue_if.master bus
`ifdef Y86_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_beats_o,
  output logic [15:0]       perf_starve_o
`endif
);
  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e            state_q;
  logic              rom_req_q;
  logic [WORD_W-1:0] rom_addr_q;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] fa_q, fa_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        buf_q [BUF_BYTES];

  logic [3:0] head_icode;
  logic [3:0] head_len;
  logic       head_err;
  logic       has_data, inst_valid, fire, ack_take, accept, space_ok;

  assign head_icode = buf_q[head_q][7:4];

  always_comb begin
    head_len = 4'd1;
    head_err = 1'b0;
    case (head_icode)
      4'h0, 4'h1, 4'h9:       head_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: head_len = 4'd2;
      4'h7, 4'h8:             head_len = 4'd5;
      4'h3, 4'h4, 4'h5:       head_len = 4'd6;
      default: begin
        head_len = 4'd1;
        head_err = 1'b1;
      end
    endcase
  end

  assign has_data   = (count_q != '0);
  assign inst_valid = has_data && (count_q >= CNT_W'(head_len));
  assign fire       = inst_valid && bus.inst_ready_i;
  assign ack_take   = rom_req_q && bus.rom_ack_i;
  assign accept     = ack_take && (state_q == S_REQ) && !bus.redirect_i;
  assign space_ok   = (CNT_W'(BUF_BYTES) - count_q) >= CNT_W'(FETCH_BYTES);

  // Redirect wins over any fire/ack landing in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    count_d = count_q;
    if (bus.redirect_i) begin
      head_d  = '0;
      tail_d  = '0;
      pc_d    = bus.redirect_pc_i;
      fa_d    = bus.redirect_pc_i;
      count_d = '0;
    end else begin
      if (fire) begin
        head_d = head_q + PTR_W'(head_len);
        pc_d   = pc_q + WORD_W'(head_len);
      end
      if (accept) begin
        tail_d = tail_q + PTR_W'(FETCH_BYTES);
        fa_d   = fa_q + WORD_W'(FETCH_BYTES);
      end
      count_d = count_q + (accept ? CNT_W'(FETCH_BYTES) : CNT_W'(0))
                        - (fire ? CNT_W'(head_len) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      fa_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      case (state_q)
        S_IDLE: begin
          rom_addr_q <= fa_d;
          if (space_ok && !bus.redirect_i) begin
            state_q   <= S_REQ;
            rom_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.rom_ack_i) begin
            state_q    <= S_IDLE;
            rom_req_q  <= 1'b0;
            rom_addr_q <= fa_d;
          end else if (bus.redirect_i) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          // Address stays on the abandoned beat until the ROM completes it.
          if (bus.rom_ack_i) begin
            state_q    <= S_IDLE;
            rom_req_q  <= 1'b0;
            rom_addr_q <= fa_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          rom_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        buf_q[tail_q + PTR_W'(k)] <= bus.rom_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    bus.inst_o = '0;
    for (int k = 0; k < INST_BYTES; k++) begin
      if (inst_valid && (k < int'(head_len))) begin
        bus.inst_o[8*k +: 8] = buf_q[head_q + PTR_W'(k)];
      end
    end
  end

  assign bus.rom_req_o    = rom_req_q;
  assign bus.rom_addr_o   = rom_addr_q;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_pc_o    = pc_q;
  assign bus.inst_len_o   = has_data ? head_len : 4'd0;
  assign bus.inst_err_o   = has_data && head_err;

`ifdef Y86_FETCH_PERF_EN
  logic [15:0] perf_beats_q, perf_starve_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_beats_q  <= '0;
      perf_starve_q <= '0;
    end else begin
      if (ack_take && (perf_beats_q != 16'hFFFF)) begin
        perf_beats_q <= perf_beats_q + 16'd1;
      end
      if (bus.inst_ready_i && !inst_valid && (perf_starve_q != 16'hFFFF)) begin
        perf_starve_q <= perf_starve_q + 16'd1;
      end
    end
  end

  assign perf_beats_o  = perf_beats_q;
  assign perf_starve_o = perf_starve_q;
`endif
endmodule
